// File: rtl/wb_uart_pkg.sv
// Shared constants, state types and helpers for the Wishbone UART.
package wb_uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int unsigned ST_W        = 7;
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_VALID = 2;
  localparam int unsigned ST_RX_OVR   = 3;
  localparam int unsigned ST_RX_FERR  = 4;
  localparam int unsigned ST_TX_OVF   = 5;
  localparam int unsigned ST_TX_BUSY  = 6;

  localparam logic [DIV_W-1:0] DIV_MIN = 16'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

  // Divisor actually used for bit timing; small values are raised to DIV_MIN.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone slave bus bundle for the UART (signal names follow Caravel's user bus).
interface wb_uart_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo
  import wb_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_d;
  logic              push_en;
  logic              pop_en;

  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push_en, pop_en})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone-slave 8N1 UART: TX FIFO, single-byte RX holding register, programmable divisor, level irq.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned      TX_FIFO_DEPTH = 8,
  parameter logic [DIV_W-1:0] DIV_RESET     = 16'd99
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  wb_uart_if.slave wb,
  input  logic     uart_rx_i,
  output logic     uart_tx_o,
  output logic     irq_o
);

  logic              acc_c, wr_c, rd_c;
  logic [1:0]        reg_c;
  logic              data_wr_c, push_c, ovf_set_c, rd_data_c, st_wr_c;
  logic [ST_W-1:0]   status_c;
  logic [31:0]       rdata_c;
  logic              unused_bits;

  logic [DIV_W-1:0]  div;
  logic              rx_valid, rx_ovr, rx_ferr, tx_ovf;
  logic [DATA_W-1:0] rx_byte;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  uart_tx_state_t    tx_state, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]        tx_bit, tx_bit_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d;
  logic              tx_pop_c, tx_line_c, tx_end_c;

  uart_rx_state_t    rx_state, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]        rx_bit, rx_bit_d;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic              rx_meta, rx_sync, rx_prev;
  logic              rx_deliver_c, rx_ferr_set_c;

  // Bus decode: an access is taken on the edge that raises ack.
  assign acc_c     = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr_c      = acc_c & wb.wb_we_i;
  assign rd_c      = acc_c & ~wb.wb_we_i;
  assign reg_c     = wb.wb_adr_i[3:2];
  assign data_wr_c = wr_c & (reg_c == REG_DATA) & wb.wb_sel_i[0];
  assign push_c    = data_wr_c & (~fifo_full | tx_pop_c);
  assign ovf_set_c = data_wr_c & fifo_full & ~tx_pop_c;
  assign rd_data_c = rd_c & (reg_c == REG_DATA) & rx_valid;
  assign st_wr_c   = wr_c & (reg_c == REG_STATUS) & wb.wb_sel_i[0];
  assign irq_o     = rx_valid;

  assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_sel_i[3:2], wb.wb_dat_i[31:16]};

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_c),
    .wdata (wb.wb_dat_i[DATA_W-1:0]),
    .pop   (tx_pop_c),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_c              = '0;
    status_c[ST_TX_FULL]  = fifo_full;
    status_c[ST_TX_EMPTY] = fifo_empty;
    status_c[ST_RX_VALID] = rx_valid;
    status_c[ST_RX_OVR]   = rx_ovr;
    status_c[ST_RX_FERR]  = rx_ferr;
    status_c[ST_TX_OVF]   = tx_ovf;
    status_c[ST_TX_BUSY]  = (tx_state != TX_IDLE);
  end

  always_comb begin
    rdata_c = '0;
    case (reg_c)
      REG_DATA:   if (rx_valid) rdata_c = {24'd0, rx_byte};
      REG_STATUS: rdata_c = {25'd0, status_c};
      REG_DIV:    rdata_c = {16'd0, div};
      default:    rdata_c = '0;
    endcase
  end

  // Register file, bus response and RX holding register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      div         <= DIV_RESET;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
      rx_ovr      <= 1'b0;
      rx_ferr     <= 1'b0;
      tx_ovf      <= 1'b0;
    end else begin
      wb.wb_ack_o <= acc_c;
      wb.wb_dat_o <= rd_c ? rdata_c : '0;
      if (wr_c && (reg_c == REG_DIV)) begin
        if (wb.wb_sel_i[0]) div[7:0]  <= wb.wb_dat_i[7:0];
        if (wb.wb_sel_i[1]) div[15:8] <= wb.wb_dat_i[15:8];
      end
      if (rx_deliver_c && (!rx_valid || rd_data_c)) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_data_c) begin
        rx_valid <= 1'b0;
      end
      if (rx_deliver_c && rx_valid && !rd_data_c) rx_ovr <= 1'b1;
      else if (st_wr_c && wb.wb_dat_i[ST_RX_OVR]) rx_ovr <= 1'b0;
      if (rx_ferr_set_c) rx_ferr <= 1'b1;
      else if (st_wr_c && wb.wb_dat_i[ST_RX_FERR]) rx_ferr <= 1'b0;
      if (ovf_set_c) tx_ovf <= 1'b1;
      else if (st_wr_c && wb.wb_dat_i[ST_TX_OVF]) tx_ovf <= 1'b0;
    end
  end

  // TX next state; a frame can launch straight out of the last stop-bit clock.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_div_d   = tx_div;
    tx_pop_c   = 1'b0;
    tx_line_c  = 1'b1;
    tx_end_c   = (tx_cnt == tx_div);
    case (tx_state)
      TX_IDLE: tx_line_c = 1'b1;
      TX_START: begin
        tx_line_c = 1'b0;
        if (tx_end_c) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt + DIV_W'(1);
        end
      end
      TX_DATA: begin
        tx_line_c = tx_sh[0];
        if (tx_end_c) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh[DATA_W-1:1]};
          tx_bit_d = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt + DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_end_c) tx_state_d = TX_IDLE;
        else          tx_cnt_d   = tx_cnt + DIV_W'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (!fifo_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end_c))) begin
      tx_pop_c   = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_sh_d    = fifo_data;
      tx_div_d   = eff_div(div);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_div    <= DIV_RESET;
      uart_tx_o <= 1'b1;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_bit    <= tx_bit_d;
      tx_sh     <= tx_sh_d;
      tx_div    <= tx_div_d;
      uart_tx_o <= tx_line_c;
    end
  end

  // RX next state: start validated at half a bit, then sampled at bit centres.
  always_comb begin
    rx_state_d    = rx_state;
    rx_cnt_d      = rx_cnt;
    rx_bit_d      = rx_bit;
    rx_sh_d       = rx_sh;
    rx_div_d      = rx_div;
    rx_deliver_c  = 1'b0;
    rx_ferr_set_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_div_d   = eff_div(div);
        end
      end
      RX_START: begin
        if (rx_cnt == (rx_div >> 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt + DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_div) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync, rx_sh[DATA_W-1:1]};
          rx_bit_d = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt + DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == rx_div) begin
          rx_deliver_c  = rx_sync;
          rx_ferr_set_c = ~rx_sync;
          rx_state_d    = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt + DIV_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_div   <= DIV_RESET;
    end else begin
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_div   <= rx_div_d;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart: register access, TX framing, RX delivery and error flags.
module tb_wb_uart;
  import wb_uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  logic irq;
  int   checks = 0;
  int   failures = 0;

  wb_uart_if bus();

  wb_uart #(.TX_FIFO_DEPTH(8), .DIV_RESET(16'd99)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .uart_rx_i (rx),
    .uart_tx_o (tx),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    logic seen;
    seen = 1'b0;
    rdat = 32'h0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = {28'd0, idx, 2'b00};
    bus.wb_dat_i = wdat;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) begin
        seen = 1'b1;
        rdat = bus.wb_dat_o;
      end
    end
    bus_idle();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wb_ack_timeout reg=%0d: no ack seen, expected ack within 4 clocks", idx);
    end
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, wdat, sel, dummy);
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] rdat);
    wb_xfer(1'b0, idx, 32'h0, 4'hF, rdat);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(per);
    end
    rx = stop_bit;
    tick(per);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    rx  = 1'b1;
    bus_idle();
    tick(3);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b expected=1", tx); end
    checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b expected=0", bus.wb_ack_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h expected=0", bus.wb_dat_o); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b expected=0", irq); end
    rst = 1'b0;
    tick(1);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL reset_status got=%h expected=00000002", r); end
    wb_read(REG_DIV, r);
    checks++; if (r !== 32'd99) begin failures++; $display("FAIL reset_div got=%0d expected=99", r); end
  endtask

  task automatic test_tx_frame();
    logic [9:0]  exp_bits;
    logic        bad;
    logic        got_bit;
    logic [31:0] r;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    wb_write(REG_DIV, 32'd3, 4'b0011);
    wb_write(REG_DATA, 32'hA5, 4'b0001);
    tick(1);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL tx_latency_early got=%b expected=1", tx); end
    tick(1);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      got_bit = exp_bits[b];
      for (int k = 0; k < 4; k++) begin
        if (tx !== exp_bits[b]) begin bad = 1'b1; got_bit = tx; end
        tick(1);
      end
      checks++;
      if (bad) begin failures++; $display("FAIL tx_a5_bit%0d got=%b expected=%b for 4 clocks", b, got_bit, exp_bits[b]); end
    end
    tick(2);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL tx_a5_idle got=%b expected=1", tx); end
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL tx_a5_status got=%h expected=00000002", r); end
  endtask

  task automatic test_div_clamp();
    logic [31:0] r;
    logic        found;
    int          low;
    wb_write(REG_DIV, 32'hFFFF_AB01, 4'b0001);
    wb_read(REG_DIV, r);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL div_bytelane got=%h expected=00000001", r); end
    wb_write(REG_DATA, 32'hFF, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (tx === 1'b0) found = 1'b1;
    end
    low = 0;
    for (int i = 0; i < 20 && tx === 1'b0; i++) begin
      low++;
      tick(1);
    end
    checks++; if (low != 4) begin failures++; $display("FAIL div_clamp_start_len got=%0d expected=4", low); end
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h42) begin failures++; $display("FAIL div_busy_status got=%h expected=00000042", r); end
    tick(45);
    wb_write(REG_DIV, 32'd3, 4'b0011);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [10];
    logic [9:0]  got;
    logic [9:0]  exp_f;
    logic [31:0] r;
    logic        found;
    logic        idle_bad;
    bytes = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h7E};
    fork
      begin
        for (int i = 0; i < 10; i++) wb_write(REG_DATA, {24'd0, bytes[i]}, 4'b0001);
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
          tick(1);
          if (tx === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
          failures++; $display("FAIL b2b_start got=no start bit expected=start within 30 clocks");
        end else begin
          tick(1);
          // The first byte leaves the FIFO at once, so nine frames go out on a fixed 40-clock grid.
          for (int f = 0; f < 9; f++) begin
            for (int b = 0; b < 10; b++) begin
              got[b] = tx;
              tick(4);
            end
            exp_f = {1'b1, bytes[f], 1'b0};
            checks++;
            if (got !== exp_f) begin failures++; $display("FAIL b2b_frame%0d got=%03h expected=%03h", f, got, exp_f); end
          end
          idle_bad = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (tx !== 1'b1) idle_bad = 1'b1;
            tick(1);
          end
          checks++;
          if (idle_bad) begin failures++; $display("FAIL b2b_tenth_dropped got=tx low expected=idle high"); end
        end
      end
    join
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h22) begin failures++; $display("FAIL b2b_status_ovf got=%h expected=00000022", r); end
    wb_write(REG_STATUS, 32'h20, 4'b0001);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h02) begin failures++; $display("FAIL b2b_ovf_clear got=%h expected=00000002", r); end
  endtask

  task automatic test_rx();
    logic [31:0] r;
    drive_frame(8'h3C, 1'b1, 4);
    tick(2);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq_set got=%b expected=1", irq); end
    wb_read(REG_DATA, r);
    checks++; if (r !== 32'h3C) begin failures++; $display("FAIL rx_data got=%h expected=0000003c", r); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clear got=%b expected=0", irq); end
    wb_read(REG_DATA, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h expected=00000000", r); end
  endtask

  task automatic test_rx_overrun_ferr();
    logic [31:0] r;
    drive_frame(8'h11, 1'b1, 4);
    drive_frame(8'h22, 1'b1, 4);
    tick(2);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h0E) begin failures++; $display("FAIL rx_ovr_status got=%h expected=0000000e", r); end
    wb_read(REG_DATA, r);
    checks++; if (r !== 32'h11) begin failures++; $display("FAIL rx_ovr_kept got=%h expected=00000011", r); end
    wb_write(REG_STATUS, 32'h08, 4'b0001);
    drive_frame(8'h5A, 1'b0, 4);
    tick(4);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h12) begin failures++; $display("FAIL rx_ferr_status got=%h expected=00000012", r); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_ferr_irq got=%b expected=0", irq); end
    wb_write(REG_STATUS, 32'h10, 4'b0001);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h02) begin failures++; $display("FAIL rx_ferr_clear got=%h expected=00000002", r); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] r;
    logic        bad;
    wb_write(REG_DIV, 32'd3, 4'b0011);
    wb_write(REG_DATA, 32'h00, 4'b0001);
    wb_write(REG_DATA, 32'h55, 4'b0001);
    wb_write(REG_DATA, 32'h66, 4'b0001);
    tick(10);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_tx_low got=%b expected=0", tx); end
    rst = 1'b1;
    tick(1);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_tx_reset_tx got=%b expected=1", tx); end
    tick(1);
    rst = 1'b0;
    tick(1);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h02) begin failures++; $display("FAIL mid_tx_reset_status got=%h expected=00000002", r); end
    wb_read(REG_DIV, r);
    checks++; if (r !== 32'd99) begin failures++; $display("FAIL mid_tx_reset_div got=%0d expected=99", r); end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) bad = 1'b1;
      tick(1);
    end
    checks++; if (bad) begin failures++; $display("FAIL mid_tx_flushed got=tx low expected=idle high"); end
  endtask

  task automatic test_rx_glitch();
    logic [31:0] r;
    wb_write(REG_DIV, 32'd7, 4'b0011);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(40);
    wb_read(REG_STATUS, r);
    checks++; if (r !== 32'h02) begin failures++; $display("FAIL rx_glitch_status got=%h expected=00000002", r); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_glitch_irq got=%b expected=0", irq); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_div_clamp();
    test_back_to_back();
    test_rx();
    test_rx_overrun_ferr();
    test_reset_mid_tx();
    test_rx_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
